// File: rtl/register_file.sv
// rtl/register_file.sv - 32 x 32-bit MIPS register file, two async read ports, one clocked write port
// Optional write-through forwarding is built when REGFILE_BYPASS_EN is defined.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  write_en;

  assign write_en = RegWrite && (WriteRegister != '0);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  always_comb begin
    ReadData1 = regs[ReadRegister1];
    ReadData2 = regs[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so a reset cycle never leaks WriteData.
    if (Rst_n && write_en && (ReadRegister1 == WriteRegister)) begin
      ReadData1 = WriteData;
    end
    if (Rst_n && write_en && (ReadRegister2 == WriteRegister)) begin
      ReadData2 = WriteData;
    end
`endif
    if (ReadRegister1 == '0) begin
      ReadData1 = '0;
    end
    if (ReadRegister2 == '0) begin
      ReadData2 = '0;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file
// Expected read pairs are queued by the stimulus and checked by a negedge monitor.
module tb_register_file;

  logic        Clk;
  logic        Rst_n;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t it;
      it = exp_q.pop_front();
      checks++;
      if (ReadData1 !== it.e1) begin
        errors++;
        $display("FAIL %s rd1 actual %h required %h", it.name, ReadData1, it.e1);
      end
      checks++;
      if (ReadData2 !== it.e2) begin
        errors++;
        $display("FAIL %s rd2 actual %h required %h", it.name, ReadData2, it.e2);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_pair(input string name, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [31:0] e1, input logic [31:0] e2);
    exp_t it;
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    it.name = name;
    it.e1   = e1;
    it.e2   = e2;
    exp_q.push_back(it);
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 32; i += 2) begin
      expect_pair(name, 5'(i), 5'(i + 1), 32'h0, 32'h0);
      step();
    end
  endtask

  initial begin
    #20000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] same_exp;
    Rst_n         = 1'b0;
    RegWrite      = 1'b0;
    WriteRegister = 5'd0;
    WriteData     = 32'h0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    step();
    Rst_n = 1'b1;
    check_all_zero("reset");

    for (int i = 8; i <= 26; i++) begin
      RegWrite      = 1'b1;
      WriteRegister = 5'(i);
      WriteData     = 32'(5 * i + 2);
      step();
    end
    RegWrite = 1'b0;
    expect_pair("fill_8_9", 5'd8, 5'd9, 32'd42, 32'd47);
    step();
    expect_pair("fill_25_26", 5'd25, 5'd26, 32'd127, 32'd132);
    step();
    for (int i = 10; i <= 24; i += 2) begin
      expect_pair("fill", 5'(i), 5'(i + 1), 32'(5 * i + 2), 32'(5 * i + 7));
      step();
    end

    for (int i = 8; i <= 25; i++) begin
      RegWrite      = 1'b0;
      WriteRegister = 5'(i);
      WriteData     = 32'hDEADBEEF;
      step();
    end
    for (int i = 8; i <= 25; i++) begin
      expect_pair("write_disabled", 5'(i), 5'(i + 1), 32'(5 * i + 2), 32'(5 * i + 7));
      step();
    end

    RegWrite      = 1'b1;
    WriteRegister = 5'd0;
    WriteData     = 32'hFFFFFFFF;
    expect_pair("zero_reg_pre", 5'd0, 5'd0, 32'h0, 32'h0);
    step();
    RegWrite = 1'b0;
    expect_pair("zero_reg_post", 5'd0, 5'd0, 32'h0, 32'h0);
    step();

`ifdef REGFILE_BYPASS_EN
    same_exp = 32'h12345678;
`else
    same_exp = 32'd52;
`endif
    RegWrite      = 1'b1;
    WriteRegister = 5'd10;
    WriteData     = 32'h12345678;
    expect_pair("same_cycle_pre", 5'd10, 5'd11, same_exp, 32'd57);
    step();
    RegWrite = 1'b0;
    expect_pair("same_cycle_post", 5'd10, 5'd10, 32'h12345678, 32'h12345678);
    step();

    Rst_n         = 1'b0;
    RegWrite      = 1'b1;
    WriteRegister = 5'd12;
    WriteData     = 32'd7;
    expect_pair("reset_mid_pre", 5'd12, 5'd10, 32'd62, 32'h12345678);
    step();
    Rst_n    = 1'b1;
    RegWrite = 1'b0;
    expect_pair("reset_mid_reg12", 5'd12, 5'd12, 32'h0, 32'h0);
    step();
    check_all_zero("reset_mid_all");

    repeat (2) @(posedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
